// File: rtl/perceptron_cmd_ctrl.sv
// Perceptron node command sequencer: decodes addressed UART frames, loads operands,
// sequences the shared multiplier, accumulates and streams results. Option: BROADCAST_EN.
module perceptron_cmd_ctrl #(
  parameter int unsigned NODE_ADDR   = 100,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic                mul_start,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                busy,
  output logic                err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [7:0]       ADDR      = 8'(NODE_ADDR);

`ifdef BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  localparam logic [7:0] OP_LOAD_A  = 8'h00;
  localparam logic [7:0] OP_LOAD_B  = 8'h01;
  localparam logic [7:0] OP_OUT_RES = 8'h02;
  localparam logic [7:0] OP_OUT_ACC = 8'h03;
  localparam logic [7:0] OP_MUL     = 8'h05;
  localparam logic [7:0] OP_MUL_ADD = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_OK,
    ST_SKIP_OP,
    ST_SKIP_PL,
    ST_PAYLOAD,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              sel_q, sel_d;
  logic              bcast_q, bcast_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] send_q, send_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              err_q, err_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              mul_start_q, mul_start_d;
  logic              busy_q, busy_d;

  logic              bcast_hit;
  logic              tmo_hit;
  logic [TMO_W-1:0]  tmo_inc;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              timed;
  logic              unused_mul_hi;

  assign bcast_hit     = BCAST_EN && (rx_data == 8'hFF);
  assign tmo_inc       = tmo_q + TMO_W'(1);
  assign tmo_hit       = (tmo_inc == TMO_LIMIT);
  assign cnt_nxt       = cnt_q + CNT_W'(1);
  assign unused_mul_hi = ^mul_p[2*DATA_W-1:DATA_W];
  assign timed = (state_q == ST_ADDR_OK) || (state_q == ST_SKIP_OP) ||
                 (state_q == ST_SKIP_PL) || (state_q == ST_PAYLOAD);

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    bcast_d     = bcast_q;
    stage_d     = stage_q;
    send_d      = send_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_d       = res_q;
    acc_d       = acc_q;
    err_d       = err_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    mul_start_d = 1'b0;
    tmo_d       = (timed && !rx_valid) ? tmo_inc : '0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cnt_d   = '0;
          bcast_d = bcast_hit;
          state_d = ((rx_data == ADDR) || bcast_hit) ? ST_ADDR_OK : ST_SKIP_OP;
        end
      end

      ST_ADDR_OK: begin
        if (rx_valid) begin
          sel_d = (rx_data == OP_LOAD_B) || (rx_data == OP_MUL_ADD) || (rx_data == OP_OUT_ACC);
          case (rx_data)
            OP_LOAD_A, OP_LOAD_B: state_d = ST_PAYLOAD;
            OP_MUL, OP_MUL_ADD: begin
              state_d     = ST_WAIT;
              mul_start_d = 1'b1;
            end
            OP_OUT_RES, OP_OUT_ACC: begin
              // Broadcast reads stay off the shared TX line; OUT_ACC still clears.
              if (bcast_q) begin
                state_d = ST_IDLE;
                if (rx_data == OP_OUT_ACC) acc_d = '0;
              end else begin
                state_d    = ST_SEND;
                send_d     = (rx_data == OP_OUT_ACC) ? acc_q : res_q;
                tx_valid_d = 1'b1;
                tx_data_d  = send_d[7:0];
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_SKIP_OP: begin
        if (rx_valid) begin
          state_d = ((rx_data == OP_LOAD_A) || (rx_data == OP_LOAD_B)) ? ST_SKIP_PL : ST_IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_SKIP_PL: begin
        if (rx_valid) begin
          cnt_d = cnt_nxt;
          if (cnt_q == LAST_BYTE) state_d = ST_IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == CNT_W'(i)) stage_d[8*i +: 8] = rx_data;
          end
          cnt_d = cnt_nxt;
          // Operand registers only ever see the complete staged word.
          if (cnt_q == LAST_BYTE) begin
            if (sel_q) mul_b_d = stage_d;
            else       mul_a_d = stage_d;
            state_d = ST_IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (rx_valid) err_d = 1'b1;
        if (mul_done) begin
          if (sel_q) acc_d = acc_q + mul_p[DATA_W-1:0];
          else       res_d = mul_p[DATA_W-1:0];
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
            if (sel_q) acc_d = '0;
          end else begin
            cnt_d = cnt_nxt;
            for (int unsigned i = 0; i < NB; i++) begin
              if (cnt_nxt == CNT_W'(i)) tx_data_d = send_q[8*i +: 8];
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      sel_q       <= 1'b0;
      bcast_q     <= 1'b0;
      stage_q     <= '0;
      send_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      sel_q       <= sel_d;
      bcast_q     <= bcast_d;
      stage_q     <= stage_d;
      send_q      <= send_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_perceptron_cmd_ctrl.sv
// Bench for perceptron_cmd_ctrl: random frames against a register-level reference model,
// with a behavioural multiplier and a TX sink with selectable back-pressure.
module tb_perceptron_cmd_ctrl;

  localparam int unsigned NODE_ADDR   = 100;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 300;
  localparam int unsigned NB          = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                tx_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                mul_start;
  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_p;
  logic                busy;
  logic                err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] ref_a, ref_b, ref_res, ref_acc;
  logic [7:0] tx_q[$];
  int rd_idx     = 0;
  int ready_mode = 0;
  int mul_lat    = 2;
  int mul_starts = 0;
  int gap_max    = 0;

  perceptron_cmd_ctrl #(
    .NODE_ADDR  (NODE_ADDR),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .mul_start(mul_start),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_done (mul_done),
    .mul_p    (mul_p),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // TX sink: a byte is taken at the edge following a negedge where valid && ready
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Multiplier: full-width product returned mul_lat cycles after the start pulse
  initial begin
    logic [2*DATA_W-1:0] prod;
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        prod = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};
        mul_starts++;
        repeat (mul_lat) @(posedge clk);
        #1;
        mul_done = 1'b1;
        mul_p    = prod;
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        mul_p    = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic do_cmd(input logic [7:0] addr, input logic [7:0] op);
    send_byte(addr);
    send_byte(op);
  endtask

  task automatic do_load(input logic [7:0] addr, input bit is_b, input logic [DATA_W-1:0] v);
    do_cmd(addr, is_b ? 8'h01 : 8'h00);
    for (int i = 0; i < NB; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic get_tx(output logic [DATA_W-1:0] v, output int n);
    v = '0;
    n = tx_q.size() - rd_idx;
    for (int i = 0; i < n && i < NB; i++) v[8*i +: 8] = tx_q[rd_idx + i];
    rd_idx = tx_q.size();
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_a = '0; ref_b = '0; ref_res = '0; ref_acc = '0;
    rd_idx = tx_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_valid, mul_start, busy, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: {tx_valid,mul_start,busy,err}=%b required 0000", {tx_valid, mul_start, busy, err});
    end
    n_cmp++;
    if ({mul_a, mul_b, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: mul_a=%h mul_b=%h tx_data=%h required 0", mul_a, mul_b, tx_data);
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, err, tx_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_release: {busy,err,tx_valid}=%b required 000", {busy, err, tx_valid});
    end
  endtask

  task automatic test_load_basic();
    logic [DATA_W-1:0] v;
    int bad;
    v = DATA_W'(1);
    bad = 0;
    do_cmd(8'(NODE_ADDR), 8'h00);
    for (int i = 0; i < NB; i++) begin
      if (mul_a !== ref_a) bad++;
      send_byte(v[8*i +: 8]);
    end
    ref_a = v;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL load_partial: mul_a changed mid-frame %0d times, required 0", bad);
    end
    n_cmp++;
    if (mul_a !== ref_a) begin
      n_fail++;
      $display("FAIL load_latency: mul_a=%h one cycle after last byte, required %h", mul_a, ref_a);
    end
    do_load(8'(NODE_ADDR), 1'b1, DATA_W'(1));
    ref_b = DATA_W'(1);
    n_cmp++;
    if ({mul_a, mul_b, err} !== {ref_a, ref_b, 1'b0} || tx_q.size() != rd_idx) begin
      n_fail++;
      $display("FAIL load_ab: mul_a=%h mul_b=%h err=%b tx=%0d required %h %h 0 0",
               mul_a, mul_b, err, tx_q.size() - rd_idx, ref_a, ref_b);
    end
  endtask

  task automatic test_mul_out();
    logic [DATA_W-1:0] got;
    int n, s0;
    s0 = mul_starts;
    do_cmd(8'(NODE_ADDR), 8'h05);
    wait_idle();
    ref_res = ref_a * ref_b;
    n_cmp++;
    if (mul_starts != s0 + 1) begin
      n_fail++;
      $display("FAIL mul_start_count: %0d pulses, required 1", mul_starts - s0);
    end
    do_cmd(8'(NODE_ADDR), 8'h02);
    n_cmp++;
    if (tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL out_latency: tx_valid=%b cycle after opcode, required 1", tx_valid);
    end
    wait_idle();
    get_tx(got, n);
    n_cmp++;
    if (n != NB || got !== ref_res) begin
      n_fail++;
      $display("FAIL out_res: %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_res);
    end
  endtask

  task automatic test_mul_add();
    logic [DATA_W-1:0] got;
    int n;
    do_load(8'(NODE_ADDR), 1'b0, 32'h0001_0001);
    do_load(8'(NODE_ADDR), 1'b1, 32'h0001_0001);
    ref_a = 32'h0001_0001;
    ref_b = 32'h0001_0001;
    for (int k = 0; k < 2; k++) begin
      do_cmd(8'(NODE_ADDR), 8'h06);
      wait_idle();
      ref_acc = ref_acc + ref_a * ref_b;
    end
    for (int k = 0; k < 2; k++) begin
      do_cmd(8'(NODE_ADDR), 8'h03);
      wait_idle();
      get_tx(got, n);
      n_cmp++;
      if (n != NB || got !== ref_acc) begin
        n_fail++;
        $display("FAIL out_acc_%0d: %0d bytes value %h, required %0d bytes %h", k, n, got, NB, ref_acc);
      end
      ref_acc = '0;
    end
  endtask

  task automatic test_foreign();
    logic [DATA_W-1:0] got;
    int n;
    do_load(8'd101, 1'b0, 32'hDEAD_BEEF);
    do_cmd(8'd101, 8'h02);
    do_load(8'd7, 1'b1, 32'h1234_5678);
    n_cmp++;
    if ({mul_a, mul_b} !== {ref_a, ref_b} || tx_q.size() != rd_idx || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL foreign: mul_a=%h mul_b=%h tx=%0d busy=%b, required %h %h 0 0",
               mul_a, mul_b, tx_q.size() - rd_idx, busy, ref_a, ref_b);
    end
    do_cmd(8'(NODE_ADDR), 8'h02);
    wait_idle();
    get_tx(got, n);
    n_cmp++;
    if (n != NB || got !== ref_res) begin
      n_fail++;
      $display("FAIL after_foreign: %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_res);
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] got;
    int n, bad;
    do_load(8'(NODE_ADDR), 1'b0, 32'hA1B2_C3D4);
    ref_a = 32'hA1B2_C3D4;
    do_cmd(8'(NODE_ADDR), 8'h05);
    wait_idle();
    ref_res = ref_a * ref_b;
    ready_mode = 2;
    do_cmd(8'(NODE_ADDR), 8'h02);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== ref_res[7:0]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d cycles with tx_valid/tx_data off, last %b/%h, required 1/%h",
               bad, tx_valid, tx_data, ref_res[7:0]);
    end
    ready_mode = 0;
    wait_idle();
    get_tx(got, n);
    n_cmp++;
    if (n != NB || got !== ref_res) begin
      n_fail++;
      $display("FAIL stall_data: %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_res);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] v, got, exp_v;
    int n, op;
    logic [7:0] fa;
    ready_mode = 1;
    gap_max = 3;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 6);
      mul_lat = $urandom_range(1, 6);
      v = $urandom;
      case (op)
        0, 1: begin
          do_load(8'(NODE_ADDR), op == 1, v);
          if (op == 1) ref_b = v;
          else         ref_a = v;
          n_cmp++;
          if ({mul_a, mul_b} !== {ref_a, ref_b}) begin
            n_fail++;
            $display("FAIL rnd_load it%0d: mul_a=%h mul_b=%h, required %h %h", it, mul_a, mul_b, ref_a, ref_b);
          end
        end
        2: begin
          do_cmd(8'(NODE_ADDR), 8'h05);
          wait_idle();
          ref_res = ref_a * ref_b;
        end
        3: begin
          do_cmd(8'(NODE_ADDR), 8'h06);
          wait_idle();
          ref_acc = ref_acc + ref_a * ref_b;
        end
        4, 5: begin
          do_cmd(8'(NODE_ADDR), (op == 5) ? 8'h03 : 8'h02);
          wait_idle();
          get_tx(got, n);
          exp_v = (op == 5) ? ref_acc : ref_res;
          if (op == 5) ref_acc = '0;
          n_cmp++;
          if (n != NB || got !== exp_v) begin
            n_fail++;
            $display("FAIL rnd_out it%0d: %0d bytes value %h, required %0d bytes %h", it, n, got, NB, exp_v);
          end
        end
        default: begin
          fa = 8'($urandom_range(101, 254));
          do_load(fa, v[0], ~v);
          n_cmp++;
          if ({mul_a, mul_b} !== {ref_a, ref_b}) begin
            n_fail++;
            $display("FAIL rnd_foreign it%0d: mul_a=%h mul_b=%h, required %h %h", it, mul_a, mul_b, ref_a, ref_b);
          end
        end
      endcase
    end
    ready_mode = 0;
    gap_max = 0;
    mul_lat = 2;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_err: err=%b after legal traffic, required 0", err);
    end
  endtask

  task automatic test_broadcast();
    logic [DATA_W-1:0] got;
    int n;
`ifdef BROADCAST_EN
    int seen;
    do_load(8'hFF, 1'b0, 32'h0000_0003);
    ref_a = 32'h0000_0003;
    n_cmp++;
    if (mul_a !== ref_a) begin
      n_fail++;
      $display("FAIL bcast_load: mul_a=%h, required %h", mul_a, ref_a);
    end
    do_cmd(8'hFF, 8'h06);
    wait_idle();
    ref_acc = ref_acc + ref_a * ref_b;
    seen = 0;
    do_cmd(8'hFF, 8'h02);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    do_cmd(8'hFF, 8'h03);
    ref_acc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || tx_q.size() != rd_idx) begin
      n_fail++;
      $display("FAIL bcast_silent: tx_valid high %0d cycles, required 0", seen);
    end
`else
    do_load(8'hFF, 1'b0, 32'h0BAD_F00D);
    n_cmp++;
    if (mul_a !== ref_a) begin
      n_fail++;
      $display("FAIL bcast_foreign: mul_a=%h, required %h", mul_a, ref_a);
    end
`endif
    do_cmd(8'(NODE_ADDR), 8'h03);
    wait_idle();
    get_tx(got, n);
    ref_acc = '0;
    n_cmp++;
    if (n != NB || got !== ref_acc) begin
      n_fail++;
      $display("FAIL bcast_acc: %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_acc);
    end
  endtask

  task automatic test_timeout();
    do_cmd(8'(NODE_ADDR), 8'h00);
    send_byte(8'd7);
    repeat (TIMEOUT_CYC - 10) @(negedge clk);
    n_cmp++;
    if ({busy, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_early: {busy,err}=%b before limit, required 10", {busy, err});
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if ({busy, err} !== 2'b01 || mul_a !== ref_a) begin
      n_fail++;
      $display("FAIL timeout_abort: {busy,err}=%b mul_a=%h, required 01 %h", {busy, err}, mul_a, ref_a);
    end
    do_load(8'(NODE_ADDR), 1'b0, 32'h5555_AAAA);
    ref_a = 32'h5555_AAAA;
    n_cmp++;
    if (mul_a !== ref_a) begin
      n_fail++;
      $display("FAIL timeout_recover: mul_a=%h, required %h", mul_a, ref_a);
    end
  endtask

  task automatic test_bad_opcode();
    apply_reset();
    do_cmd(8'(NODE_ADDR), 8'h09);
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_opcode: {busy,err}=%b, required 01", {busy, err});
    end
  endtask

  task automatic test_overrun();
    logic [DATA_W-1:0] got;
    int n;
    apply_reset();
    do_load(8'(NODE_ADDR), 1'b0, 32'h0000_1234);
    do_load(8'(NODE_ADDR), 1'b1, 32'h0000_0101);
    ref_a = 32'h0000_1234;
    ref_b = 32'h0000_0101;
    mul_lat = 20;
    do_cmd(8'(NODE_ADDR), 8'h05);
    send_byte(8'(NODE_ADDR));
    wait_idle();
    ref_res = ref_a * ref_b;
    mul_lat = 2;
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_wait_err: err=%b, required 1", err);
    end
    ready_mode = 2;
    do_cmd(8'(NODE_ADDR), 8'h02);
    send_byte(8'h55);
    send_byte(8'h02);
    ready_mode = 0;
    wait_idle();
    get_tx(got, n);
    n_cmp++;
    if (n != NB || got !== ref_res) begin
      n_fail++;
      $display("FAIL overrun_send: %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_res);
    end
  endtask

  task automatic test_reset_midop();
    logic [DATA_W-1:0] got;
    int n;
    do_load(8'(NODE_ADDR), 1'b0, 32'h0000_0777);
    ref_a = 32'h0000_0777;
    mul_lat = 12;
    do_cmd(8'(NODE_ADDR), 8'h06);
    repeat (3) @(posedge clk);
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, mul_a} !== {1'b0, ref_a}) begin
      n_fail++;
      $display("FAIL reset_midop: busy=%b mul_a=%h, required 0 %h", busy, mul_a, ref_a);
    end
    repeat (20) @(negedge clk);
    mul_lat = 2;
    do_cmd(8'(NODE_ADDR), 8'h03);
    wait_idle();
    get_tx(got, n);
    n_cmp++;
    if (n != NB || got !== ref_acc) begin
      n_fail++;
      $display("FAIL late_done: acc %0d bytes value %h, required %0d bytes %h", n, got, NB, ref_acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    test_reset();
    test_load_basic();
    test_mul_out();
    test_mul_add();
    test_foreign();
    test_stall();
    test_random();
    test_broadcast();
    test_timeout();
    test_bad_opcode();
    test_overrun();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
